// File: rtl/arbitro_escritura_br_if.sv
// arbitro_escritura_br_if: two writeback requesters plus the register-bank write port
interface arbitro_escritura_br_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                 req0_valid;
  logic [ADDR_W-1:0]    req0_addr;
  logic [DATA_W-1:0]    req0_data;
  logic                 req0_ready;
  logic                 req1_valid;
  logic [ADDR_W-1:0]    req1_addr;
  logic [DATA_W-1:0]    req1_data;
  logic                 req1_ready;
  logic                 RegWrite;
  logic [ADDR_W-1:0]    AWrite;
  logic [DATA_W-1:0]    DataIn;
  logic [2**ADDR_W-1:0] pend_mask;
  modport master (
    output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready, RegWrite, AWrite, DataIn, pend_mask
  );
  modport slave (
    input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready, RegWrite, AWrite, DataIn, pend_mask
  );
endinterface

// File: rtl/arbitro_escritura_br.sv
// arbitro_escritura_br: one-entry buffers per requester, round-robin with age override, single bank write port
module arbitro_escritura_br #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic clk,
  input logic rst,
  arbitro_escritura_br_if.slave bus
);
  localparam int NREG = 2**ADDR_W;
  logic              full0_q, full0_d, full1_q, full1_d;
  logic              old0_q, old0_d, last_q, last_d, wr_q, wr_d;
  logic [ADDR_W-1:0] addr0_q, addr0_d, addr1_q, addr1_d, aw_q, aw_d;
  logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d, dw_q, dw_d;
  logic              grant0, grant1, ready0, ready1, xfer0, xfer1;
  logic [NREG-1:0]   pend;
  // same-address pairs go oldest-first so the bank ends with the newest value
  always_comb begin
    grant0  = full0_q & (!full1_q | ((addr0_q == addr1_q) ? old0_q : last_q));
    grant1  = full1_q & !grant0;
    ready0  = !rst & (!full0_q | grant0);
    ready1  = !rst & (!full1_q | grant1);
    xfer0   = bus.req0_valid & ready0;
    xfer1   = bus.req1_valid & ready1;
    full0_d = xfer0 | (full0_q & !grant0);
    full1_d = xfer1 | (full1_q & !grant1);
    addr0_d = xfer0 ? bus.req0_addr : addr0_q;
    data0_d = xfer0 ? bus.req0_data : data0_q;
    addr1_d = xfer1 ? bus.req1_addr : addr1_q;
    data1_d = xfer1 ? bus.req1_data : data1_q;
    old0_d  = (xfer0 & xfer1) ? 1'b1 : xfer0 ? !(full1_q & !grant1) : xfer1 ? 1'b1 : old0_q;
    last_d  = grant0 ? 1'b0 : grant1 ? 1'b1 : last_q;
    wr_d    = grant0 | grant1;
    aw_d    = grant0 ? addr0_q : grant1 ? addr1_q : aw_q;
    dw_d    = grant0 ? data0_q : grant1 ? data1_q : dw_q;
    pend    = rst ? '0 : (({NREG{full0_q}} & (NREG'(1) << addr0_q)) |
                          ({NREG{full1_q}} & (NREG'(1) << addr1_q)));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      full0_q <= 1'b0;
      full1_q <= 1'b0;
      old0_q  <= 1'b0;
      last_q  <= 1'b1;
      wr_q    <= 1'b0;
      aw_q    <= '0;
      dw_q    <= '0;
      addr0_q <= '0;
      data0_q <= '0;
      addr1_q <= '0;
      data1_q <= '0;
    end else begin
      full0_q <= full0_d;
      full1_q <= full1_d;
      old0_q  <= old0_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      aw_q    <= aw_d;
      dw_q    <= dw_d;
      addr0_q <= addr0_d;
      data0_q <= data0_d;
      addr1_q <= addr1_d;
      data1_q <= data1_d;
    end
  end
  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.RegWrite   = wr_q;
  assign bus.AWrite     = aw_q;
  assign bus.DataIn     = dw_q;
  assign bus.pend_mask  = pend;
endmodule
